audio_playback_arbiter: RTL and testbench

- Shares the single playback-buffer write port of the audio unit between NUM_REQ sample producers (sampler voices, test tone, etc.).
- Once per audio frame (frame_tick), grants each enabled producer exactly one 64-bit stereo sample write, in round-robin order, throttled by buffer-full backpressure.
- Flags underrun when a frame_tick arrives before all enabled producers are served.

---
 rtl/audio_playback_arbiter.sv | 162 ++++++++++++++++
 tb/tb_audio_playback_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_playback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : audio_playback_arbiter
// Purpose : Round-robin, once-per-frame arbiter for the playback-buffer write
//           port, with full-buffer throttling and sticky underrun detection.
// Revision: 1.0
// ============================================================================
module audio_playback_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 64
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      frame_tick,
    input  logic [NUM_REQ-1:0]        enable_mask,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [DATA_W-1:0]         pb_data,
    output logic                      pb_wr,
    input  logic                      pb_full,
    output logic [NUM_REQ-1:0]        served_mask,
    output logic                      frame_done,
    output logic                      underrun,
    input  logic                      underrun_clr
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        XFER = 2'd2,
        WR   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt;
    logic [PTR_W-1:0]   grant, grant_nxt;
    logic [NUM_REQ-1:0] pending, pending_nxt;
    logic [NUM_REQ-1:0] served_nxt, ready_nxt, cand;
    logic [DATA_W-1:0]  data_nxt;
    logic               wr_nxt, done_nxt, underrun_nxt;
    logic [PTR_W-1:0]   pick;
    logic               pick_ok;

    assign cand = pending & req_valid;

    // First candidate at or above rr_ptr, wrapping around.
    always_comb begin : p_pick
        int               idx;
        logic [PTR_W-1:0] pos;
        pick    = '0;
        pick_ok = 1'b0;
        idx     = 0;
        pos     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            pos = PTR_W'(idx);
            if (!pick_ok && cand[pos]) begin
                pick_ok = 1'b1;
                pick    = pos;
            end
        end
    end

    always_comb begin : p_next
        state_nxt    = state;
        pending_nxt  = pending;
        served_nxt   = served_mask;
        ready_nxt    = '0;
        data_nxt     = pb_data;
        wr_nxt       = 1'b0;
        done_nxt     = 1'b0;
        rr_nxt       = rr_ptr;
        grant_nxt    = grant;
        underrun_nxt = underrun & ~underrun_clr;

        case (state)
            IDLE: begin
                if (frame_tick) begin
                    pending_nxt = enable_mask;
                    served_nxt  = '0;
                    if (enable_mask == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = SCAN;
                    end
                end
            end
            SCAN: begin
                if (!pb_full && pick_ok) begin
                    grant_nxt       = pick;
                    ready_nxt[pick] = 1'b1;
                    state_nxt       = XFER;
                end
            end
            XFER: begin
                data_nxt           = req_data[grant*DATA_W +: DATA_W];
                wr_nxt             = 1'b1;
                pending_nxt[grant] = 1'b0;
                served_nxt[grant]  = 1'b1;
                rr_nxt             = (grant == PTR_W'(NUM_REQ - 1)) ? '0 : grant + PTR_W'(1);
                state_nxt          = WR;
            end
            WR: begin
                if (pending != '0) begin
                    state_nxt = SCAN;
                end else begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Frame overrun: restart the frame, but let a committed write finish.
        if (frame_tick && (state != IDLE)) begin
            underrun_nxt = 1'b1;
            pending_nxt  = enable_mask;
            served_nxt   = '0;
            ready_nxt    = '0;
            done_nxt     = 1'b0;
            if (state == XFER) begin
                state_nxt = WR;
            end else if (enable_mask == '0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = SCAN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            pending     <= '0;
            served_mask <= '0;
            req_ready   <= '0;
            pb_data     <= '0;
            pb_wr       <= 1'b0;
            frame_done  <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr_ptr      <= rr_nxt;
            grant       <= grant_nxt;
            pending     <= pending_nxt;
            served_mask <= served_nxt;
            req_ready   <= ready_nxt;
            pb_data     <= data_nxt;
            pb_wr       <= wr_nxt;
            frame_done  <= done_nxt;
            underrun    <= underrun_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_playback_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_audio_playback_arbiter
// Purpose : Directed bench with write scoreboard for audio_playback_arbiter.
// Revision: 1.0
// ============================================================================
module tb_audio_playback_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 64;

    logic                      clock;
    logic                      reset;
    logic                      frame_tick;
    logic [NUM_REQ-1:0]        enable_mask;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]         pb_data;
    logic                      pb_wr;
    logic                      pb_full;
    logic [NUM_REQ-1:0]        served_mask;
    logic                      frame_done;
    logic                      underrun;
    logic                      underrun_clr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        int idx;
    } wr_t;

    wr_t         plan[$];
    logic [63:0] sb[$];

    audio_playback_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .enable_mask  (enable_mask),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .pb_data      (pb_data),
        .pb_wr        (pb_wr),
        .pb_full      (pb_full),
        .served_mask  (served_mask),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] dat(input int i);
        return 64'h1111_0000_0000_0000 | 64'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_wr(input int cyc, input int idx);
        wr_t w;
        w.cyc = cyc;
        w.idx = idx;
        plan.push_back(w);
        sb.push_back(dat(idx));
    endtask

    // Every pb_wr must carry the oldest outstanding expected sample.
    always @(negedge clock) begin
        if (reset === 1'b1 && pb_wr === 1'b1) begin
            if (sb.size() == 0) chk("unexpected_wr", 64'(pb_wr), 64'd0);
            else                chk("pb_data", pb_data, sb.pop_front());
        end
    end

    // Walks cycles c0+1..c1 relative to the frame_tick cycle, driving the
    // per-cycle stimulus and checking pb_wr / req_ready / frame_done timing.
    task automatic run(input int c0, input int c1, input int done_cyc, input int full_to,
                       input int late_cyc, input logic [3:0] late_valid,
                       input int tick2_cyc, input logic [3:0] tick2_mask);
        logic       exp_wr;
        logic [3:0] exp_rdy;
        for (int c = c0 + 1; c <= c1; c++) begin
            step();
            frame_tick = (c == tick2_cyc);
            if (c == tick2_cyc) enable_mask = tick2_mask;
            pb_full = (c <= full_to);
            if (c == late_cyc) req_valid = late_valid;
            exp_wr  = 1'b0;
            exp_rdy = 4'b0000;
            foreach (plan[k]) begin
                if (plan[k].cyc == c)     exp_wr  = 1'b1;
                if (plan[k].cyc == c + 1) exp_rdy = 4'b0001 << plan[k].idx;
            end
            chk($sformatf("pb_wr@%0d", c), 64'(pb_wr), 64'(exp_wr));
            chk($sformatf("req_ready@%0d", c), 64'(req_ready), 64'(exp_rdy));
            chk($sformatf("frame_done@%0d", c), 64'(frame_done), 64'(c == done_cyc));
        end
    endtask

    initial begin
        reset        = 1'b0;
        frame_tick   = 1'b0;
        enable_mask  = '0;
        req_valid    = '0;
        pb_full      = 1'b0;
        underrun_clr = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = dat(i);

        // Reset state
        step();
        step();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_pb_data", pb_data, 64'd0);
        chk("rst_pb_wr", 64'(pb_wr), 64'd0);
        chk("rst_served", 64'(served_mask), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_underrun", 64'(underrun), 64'd0);
        reset = 1'b1;
        step();

        // Basic frame: all four requesters in order
        enable_mask = 4'b1111;
        req_valid   = 4'b1111;
        for (int i = 0; i < 4; i++) expect_wr(3 + 3 * i, i);
        frame_tick = 1'b1;
        run(0, 13, 13, -1, -1, 4'b0, -1, 4'b0);
        chk("basic_served", 64'(served_mask), 64'hF);
        chk("basic_underrun", 64'(underrun), 64'd0);
        chk("basic_sb_empty", 64'(sb.size()), 64'd0);
        plan.delete();
        step();

        // Round-robin under pb_full, then wrap of rr_ptr into next frame
        enable_mask = 4'b0101;
        expect_wr(8, 0);
        expect_wr(11, 2);
        frame_tick = 1'b1;
        pb_full    = 1'b1;
        run(0, 12, 12, 5, -1, 4'b0, -1, 4'b0);
        plan.delete();
        step();
        expect_wr(3, 0);
        expect_wr(6, 2);
        frame_tick = 1'b1;
        run(0, 7, 7, -1, -1, 4'b0, -1, 4'b0);
        chk("rr_sb_empty", 64'(sb.size()), 64'd0);
        plan.delete();
        step();

        // Late valid on requester 1
        enable_mask = 4'b0011;
        req_valid   = 4'b0001;
        expect_wr(3, 0);
        expect_wr(23, 1);
        frame_tick = 1'b1;
        run(0, 24, 24, -1, 21, 4'b0011, -1, 4'b0);
        chk("late_served", 64'(served_mask), 64'h3);
        chk("late_sb_empty", 64'(sb.size()), 64'd0);
        plan.delete();
        step();

        // Underrun: requester 3 never valid, second tick at cycle 30
        enable_mask = 4'b1111;
        req_valid   = 4'b0111;
        expect_wr(3, 2);
        expect_wr(6, 0);
        expect_wr(9, 1);
        expect_wr(33, 2);
        expect_wr(36, 0);
        expect_wr(39, 1);
        frame_tick = 1'b1;
        run(0, 31, -1, -1, -1, 4'b0, 30, 4'b0111);
        chk("ur_flag", 64'(underrun), 64'd1);
        chk("ur_served_clr", 64'(served_mask), 64'd0);
        run(31, 40, 40, -1, -1, 4'b0, -1, 4'b0);
        chk("ur_sticky", 64'(underrun), 64'd1);
        chk("ur_sb_empty", 64'(sb.size()), 64'd0);
        plan.delete();
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("ur_cleared", 64'(underrun), 64'd0);

        // Empty frame
        enable_mask = 4'b0000;
        frame_tick  = 1'b1;
        run(0, 3, 1, -1, -1, 4'b0, -1, 4'b0);
        chk("empty_served", 64'(served_mask), 64'd0);

        // Underrun set and clear in the same cycle: set wins
        enable_mask = 4'b1000;
        req_valid   = 4'b0000;
        frame_tick  = 1'b1;
        step();
        enable_mask  = 4'b0000;
        underrun_clr = 1'b1;
        step();
        frame_tick   = 1'b0;
        underrun_clr = 1'b0;
        chk("set_wins", 64'(underrun), 64'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("clr_after_set", 64'(underrun), 64'd0);
        step();

        // Reset during XFER (rr_ptr is 2 here, so requester 2 is granted)
        enable_mask = 4'b1111;
        req_valid   = 4'b1111;
        frame_tick  = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
        chk("pre_rst_ready", 64'(req_ready), 64'h4);
        reset = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_wr", 64'(pb_wr), 64'd0);
        chk("mid_rst_served", 64'(served_mask), 64'd0);
        step();
        step();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            chk($sformatf("post_rst_no_wr@%0d", c), 64'(pb_wr), 64'd0);
        end
        // rr_ptr back at 0 after reset
        for (int i = 0; i < 4; i++) expect_wr(3 + 3 * i, i);
        frame_tick = 1'b1;
        run(0, 13, 13, -1, -1, 4'b0, -1, 4'b0);
        chk("post_rst_sb_empty", 64'(sb.size()), 64'd0);
        plan.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
